// File: rtl/pll_mdrp_pkg.sv
// Shared encodings for the PLLA MDRP sequencer: MDRP opcodes, command opcodes,
// controller state enum and counter width.
package pll_mdrp_pkg;

    localparam int CNT_W = 24;

    localparam logic [1:0] MDOPC_NOP  = 2'b00;
    localparam logic [1:0] MDOPC_ADDR = 2'b11;
    localparam logic [1:0] MDOPC_WR   = 2'b01;
    localparam logic [1:0] MDOPC_RD   = 2'b10;

    localparam logic [1:0] CMD_RD    = 2'b00;
    localparam logic [1:0] CMD_WR    = 2'b01;
    localparam logic [1:0] CMD_APPLY = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_OP        = 3'd2,
        ST_RWAIT     = 3'd3,
        ST_APPLY_RST = 3'd4,
        ST_LOCK_WAIT = 3'd5,
        ST_RESP      = 3'd6
    } state_e;

    // Register accesses share the address-load / opcode prologue.
    function automatic logic is_mdrp_op(input logic [1:0] op);
        return (op == CMD_RD) || (op == CMD_WR);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a synchronous clear used to flush stale lock
// state while the PLL is held in reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = clr ? 1'b0 : d;
        s2_d = clr ? 1'b0 : s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// PLLA MDRP sequencer: register read/write over MDRP and a reset+lock "apply".
// Define PLL_MDRP_VERIFY_EN to add a readback-and-compare after every write.
module pll_mdrp_ctrl
    import pll_mdrp_pkg::*;
#(
    parameter int READ_LAT     = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    input  logic       pll_lock
);

    localparam logic [CNT_W-1:0] RL_LAST  = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rb_q, rb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic [1:0]       mdopc_q, mdopc_d;
    logic [7:0]       mdwdi_q, mdwdi_d;
    logic             pll_reset_q, pll_reset_d;
    logic             lock_sync;
    logic             lock_clr;

    // Flushing during reset keeps a lock left over from before the apply out of LOCK_WAIT.
    assign lock_clr = (state_q == ST_APPLY_RST);

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lock_clr),
        .d     (pll_lock),
        .q     (lock_sync)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rb_d        = rb_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rb_d    = 1'b0;
                    if (is_mdrp_op(cmd_op)) begin
                        state_d = ST_ADDR;
                    end else if (cmd_op == CMD_APPLY) begin
                        state_d = ST_APPLY_RST;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                state_d = ST_OP;
            end
            ST_OP: begin
                cnt_d = '0;
                if (op_q == CMD_WR && !rb_q) begin
`ifdef PLL_MDRP_VERIFY_EN
                    // Second pass through ADDR/OP issues the readback read.
                    state_d = ST_ADDR;
                    rb_d    = 1'b1;
`else
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (cnt_q == RL_LAST) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    rsp_rdata_d = mdrdo;
`ifdef PLL_MDRP_VERIFY_EN
                    rsp_err_d   = rb_q && (mdrdo != wdata_q);
`else
                    rsp_err_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_LOCK_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK_WAIT: begin
                // Lock is tested first so a lock on the timeout cycle still succeeds.
                if (lock_sync) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        pll_reset_d = (state_d == ST_APPLY_RST);
        mdopc_d     = MDOPC_NOP;
        mdwdi_d     = '0;
        if (state_d == ST_ADDR) begin
            mdopc_d = MDOPC_ADDR;
            mdwdi_d = addr_d;
        end else if (state_d == ST_OP) begin
            if (op_d == CMD_WR && !rb_d) begin
                mdopc_d = MDOPC_WR;
                mdwdi_d = wdata_d;
            end else begin
                mdopc_d = MDOPC_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= CMD_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rb_q        <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mdopc_q     <= MDOPC_NOP;
            mdwdi_q     <= '0;
            pll_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rb_q        <= rb_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mdopc_q     <= mdopc_d;
            mdwdi_q     <= mdwdi_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign mdclk     = clk;
    assign mdopc     = mdopc_q;
    assign mdainc    = 1'b0;
    assign mdwdi     = mdwdi_q;
    assign pll_reset = pll_reset_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Scoreboard bench for pll_mdrp_ctrl: directed and random commands against a
// cycle-level reference of responses, MDRP transfers and PLL reset windows.
module tb_pll_mdrp_ctrl;

    localparam int READ_LAT     = 2;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 200;
    localparam int NEVER        = -1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] mdrdo = 8'h00;
    logic       pll_lock = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_err, busy, mdclk, mdainc, pll_reset;
    logic [7:0] rsp_rdata, mdwdi;
    logic [1:0] mdopc;

    pll_mdrp_ctrl #(
        .READ_LAT     (READ_LAT),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mdclk     (mdclk),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo),
        .pll_reset (pll_reset),
        .pll_lock  (pll_lock)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [40:0] exp_q[$];   // {cycle, rdata, err}
    logic [41:0] md_q[$];    // {cycle, mdopc, mdwdi}
    logic [63:0] rst_q[$];   // {start cycle, high cycles}
    logic [7:0]  pll_regs[256];
    logic [7:0]  ref_regs[256];
    logic [7:0]  pll_addr = 8'h00;
    logic [7:0]  corrupt = 8'h00;
    logic [7:0]  rd_x = 8'h00;
    int          rd_due = -100;
    int          ready_cyc = 0;
    int          rst_len = 0;
    int          rst_start = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 5000) begin
            step();
            g++;
        end
    endtask

    // ---------------- PLL MDRP model ----------------
    always @(negedge clk) begin
        if (cyc == rd_due) mdrdo = pll_regs[pll_addr] ^ rd_x;
        else               mdrdo = 8'($urandom);
        case (mdopc)
            2'b11: pll_addr = mdwdi;
            2'b01: pll_regs[pll_addr] = mdwdi;
            2'b10: begin
                rd_due = cyc + READ_LAT;
                rd_x   = corrupt;
            end
            default: ;
        endcase
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [40:0] e;
        logic [41:0] m;
        logic [63:0] w;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected at cycle %0d: got rdata=%0h err=%0b, expected no response", cyc, rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp{cyc,rdata,err}", 64'({32'(cyc), rsp_rdata, rsp_err}), 64'(e));
            end
        end
        if (mdopc !== 2'b00 || (md_q.size() > 0 && md_q[0][41:10] == 32'(cyc))) begin
            if (md_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mdrp_unexpected at cycle %0d: got mdopc=%0b mdwdi=%0h, expected nop", cyc, mdopc, mdwdi);
            end else begin
                m = md_q.pop_front();
                check("mdrp{cyc,opc,wdi}", 64'({32'(cyc), mdopc, mdwdi}), 64'(m));
            end
        end
        if (pll_reset === 1'b1) begin
            if (rst_len == 0) rst_start = cyc;
            rst_len++;
        end else if (rst_len > 0) begin
            if (rst_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pll_reset_unexpected at cycle %0d: got start=%0d len=%0d, expected none", cyc, rst_start, rst_len);
            end else begin
                w = rst_q.pop_front();
                check("pll_reset{start,len}", {32'(rst_start), 32'(rst_len)}, w);
            end
            rst_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         output int a);
        int c;
        c = cyc;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        a = (c > ready_cyc) ? c : ready_cyc;
        while (cyc < a) begin
            check("cmd_ready_while_busy", 64'(cmd_ready), 64'(0));
            step();
        end
        check("cmd_ready_at_accept", 64'(cmd_ready), 64'(1));
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] wdata);
        int a, t;
        issue(2'b01, addr, wdata, a);
        ref_regs[addr] = wdata;
        md_q.push_back({32'(a + 1), 2'b11, addr});
        md_q.push_back({32'(a + 2), 2'b01, wdata});
`ifdef PLL_MDRP_VERIFY_EN
        corrupt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        md_q.push_back({32'(a + 3), 2'b11, addr});
        md_q.push_back({32'(a + 4), 2'b10, 8'h00});
        t = a + 5 + READ_LAT;
        exp_q.push_back({32'(t), wdata ^ corrupt, corrupt != 8'h00});
        ready_cyc = t + 1;
        wait_cyc(t + 1);
        corrupt = 8'h00;
`else
        t = a + 3;
        exp_q.push_back({32'(t), 8'h00, 1'b0});
        ready_cyc = t + 1;
`endif
    endtask

    task automatic do_read(input logic [7:0] addr);
        int a, t;
        issue(2'b00, addr, 8'($urandom), a);
        md_q.push_back({32'(a + 1), 2'b11, addr});
        md_q.push_back({32'(a + 2), 2'b10, 8'h00});
        t = a + 3 + READ_LAT;
        exp_q.push_back({32'(t), ref_regs[addr], 1'b0});
        ready_cyc = t + 1;
    endtask

    task automatic do_rsvd();
        int a;
        issue(2'b11, 8'($urandom), 8'($urandom), a);
        exp_q.push_back({32'(a + 1), 8'h00, 1'b1});
        ready_cyc = a + 2;
    endtask

    // d = cycles after reset release at which the PLL raises lock (NEVER: stays low).
    task automatic do_apply(input int d);
        int a, r, t;
        logic e;
        issue(2'b10, 8'($urandom), 8'($urandom), a);
        r = a + 1 + RST_CYCLES;
        rst_q.push_back({32'(a + 1), 32'(RST_CYCLES)});
        if (d != NEVER && d + 2 <= LOCK_TIMEOUT - 1) begin
            t = r + d + 3;
            e = 1'b0;
        end else begin
            t = r + LOCK_TIMEOUT;
            e = 1'b1;
        end
        exp_q.push_back({32'(t), 8'h00, e});
        ready_cyc = t + 1;
        wait_cyc(r);
        pll_lock = (d == 0);
        if (d > 0) begin
            wait_cyc(r + d);
            pll_lock = 1'b1;
        end
        wait_cyc(t + 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_rsp{valid,rdata,err}"}, 64'({rsp_valid, rsp_rdata, rsp_err}), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_md{opc,ainc,wdi}"}, 64'({mdopc, mdainc, mdwdi}), 64'(0));
        check({tag, "_pll_reset"}, 64'(pll_reset), 64'(0));
    endtask

    task automatic do_abort_in_reset();
        int a;
        issue(2'b10, 8'h00, 8'h00, a);
        rst_q.push_back({32'(a + 1), 32'(4)});
        wait_cyc(a + 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        step();
        step();
        rst_n = 1'b1;
        ready_cyc = cyc;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r, g;
        for (int i = 0; i < 256; i++) begin
            pll_regs[i] = 8'($urandom);
            ref_regs[i] = pll_regs[i];
        end
        pll_regs[8'h34] = 8'h5C;
        ref_regs[8'h34] = 8'h5C;

        step();
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        ready_cyc = cyc;
        step();

        do_write(8'h12, 8'hA5);
        do_read(8'h34);
        do_read(8'h12);
        do_apply(50);
        do_apply(NEVER);
        do_apply(LOCK_TIMEOUT - 3);
        do_apply(LOCK_TIMEOUT - 2);
        do_apply(0);
        do_rsvd();
        do_write(8'h07, 8'h3C);
        do_read(8'h07);
        do_rsvd();
        do_read(8'h34);
        do_abort_in_reset();
        do_read(8'h07);

        for (int n = 0; n < 80; n++) begin
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) step();
            r = $urandom_range(0, 99);
            if (r < 40)      do_read(8'($urandom_range(0, 15)));
            else if (r < 80) do_write(8'($urandom_range(0, 15)), 8'($urandom));
            else if (r < 90) begin
                g = $urandom_range(0, 230);
                do_apply((g > 215) ? NEVER : g);
            end
            else             do_rsvd();
        end

        g = 0;
        while ((exp_q.size() != 0 || md_q.size() != 0 || rst_q.size() != 0) && g < 3000) begin
            step();
            g++;
        end
        step();
        step();
        if (exp_q.size() != 0 || md_q.size() != 0 || rst_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d rsp / %0d mdrp / %0d reset items outstanding, expected 0",
                     exp_q.size(), md_q.size(), rst_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
